// File: rtl/grid_uart_tx_pkg.sv
// Shared definitions for the serial board dumper: cell codes, ASCII
// characters, board geometry, frame lengths and the sequencer states.
package grid_uart_tx_pkg;

  localparam int GRID_ROWS = 7;
  localparam int GRID_COLS = 7;

  // Each board row is COLS cell characters followed by CR LF.
  localparam int BOARD_LEN   = GRID_ROWS * (GRID_COLS + 2);
  // 'W', winner digit, CR, LF.
  localparam int TRAILER_LEN = 4;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  localparam logic [7:0] ASCII_DOT  = 8'h2E;
  localparam logic [7:0] ASCII_X    = 8'h58;
  localparam logic [7:0] ASCII_O    = 8'h4F;
  localparam logic [7:0] ASCII_QM   = 8'h3F;
  localparam logic [7:0] ASCII_W    = 8'h57;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_NEXT,
    ST_FIN
  } state_t;

  // Printable character for one 2-bit cell; the reserved code shows as '?'.
  function automatic logic [7:0] cell_char(input logic [1:0] code);
    logic [7:0] ch;
    case (code)
      CELL_EMPTY: ch = ASCII_DOT;
      CELL_P1:    ch = ASCII_X;
      CELL_P2:    ch = ASCII_O;
      default:    ch = ASCII_QM;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. Owns the baud and bit counters. 'ready' also rises
// during the last two cycles of the stop bit so the frame sequencer can
// prepare the next byte and keep the idle gap between bytes short.
module uart_tx_byte
  import grid_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_EARLY = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [3:0]        BIT_LAST   = 4'd9;

  logic              active_reg;
  logic [9:0]        shift_reg;
  logic [3:0]        bit_reg;
  logic [BAUD_W-1:0] baud_reg;
  logic              finishing;

  assign finishing = active_reg && (bit_reg == BIT_LAST) && (baud_reg >= BAUD_EARLY);
  assign ready     = !active_reg || finishing;
  // Line is high whenever no byte is in flight, including straight out of reset.
  assign tx        = !active_reg || shift_reg[0];

  // Load {stop, data, start} on start, then shift one bit per baud period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_reg <= 1'b0;
      shift_reg  <= '1;
      bit_reg    <= '0;
      baud_reg   <= '0;
    end else if (!active_reg) begin
      if (start) begin
        active_reg <= 1'b1;
        shift_reg  <= {1'b1, data, 1'b0};
        bit_reg    <= '0;
        baud_reg   <= '0;
      end
    end else if (baud_reg == BAUD_LAST) begin
      baud_reg <= '0;
      if (bit_reg == BIT_LAST) begin
        active_reg <= 1'b0;
        bit_reg    <= '0;
      end else begin
        bit_reg   <= bit_reg + 4'd1;
        shift_reg <= {1'b1, shift_reg[9:1]};
      end
    end else begin
      baud_reg <= baud_reg + BAUD_W'(1);
    end
  end

endmodule

// File: rtl/grid_uart_tx.sv
// Serial board dumper: snapshots the grid and game status on request and
// streams the board as ASCII rows (top row first) over an 8N1 UART line.
module grid_uart_tx
  import grid_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ROWS         = GRID_ROWS,
  parameter int COLS         = GRID_COLS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     send,
  input  logic [ROWS*COLS*2-1:0]   grid,
  input  logic [1:0]               winner,
  input  logic                     term,
  output logic                     tx,
  output logic                     busy,
  output logic                     done
);

  localparam int CELLS       = ROWS * COLS;
  localparam int BOARD_BYTES = ROWS * (COLS + 2);
  localparam int FRAME_MAX   = BOARD_BYTES + TRAILER_LEN;
  localparam int IDX_W       = $clog2(FRAME_MAX);
  localparam int COL_W       = $clog2(COLS + 2);
  localparam int ROW_W       = $clog2(ROWS);
  localparam int CELL_W      = $clog2(CELLS);

  state_t              state_reg, state_next;
  logic [2*CELLS-1:0]  grid_snap_reg;
  logic [1:0]          winner_snap_reg;
  logic                term_snap_reg;
  logic                pending_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [COL_W-1:0]    col_reg;
  logic [ROW_W-1:0]    row_reg;     // 0 = top board row (row ROWS-1)

  logic                byte_start;
  logic                byte_ready;
  logic [7:0]          byte_data;
  logic                restart;
  logic                take_snapshot;
  logic                last_byte;
  logic [IDX_W-1:0]    last_idx;
  logic [IDX_W-1:0]    trail_off;
  logic [CELL_W-1:0]   cell_idx;
  logic [1:0]          cells [CELLS];

  genvar gi;
  generate
    for (gi = 0; gi < CELLS; gi++) begin : g_cells
      assign cells[gi] = grid_snap_reg[2*gi +: 2];
    end
  endgenerate

  // A send arriving on the FIN cycle itself counts like a queued one.
  assign restart       = pending_reg | send;
  assign take_snapshot = ((state_reg == ST_IDLE) && send) ||
                         ((state_reg == ST_FIN) && restart);
  assign last_idx      = term_snap_reg ? IDX_W'(FRAME_MAX - 1) : IDX_W'(BOARD_BYTES - 1);
  assign last_byte     = (idx_reg == last_idx);
  assign trail_off     = idx_reg - IDX_W'(BOARD_BYTES);

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk   (clk),
    .rst   (rst),
    .start (byte_start),
    .data  (byte_data),
    .tx    (tx),
    .ready (byte_ready)
  );

  // Character mux: board cell, row terminator, or trailer byte.
  always_comb begin
    cell_idx  = CELL_W'((ROWS - 1 - int'(row_reg)) * COLS + int'(col_reg));
    byte_data = ASCII_LF;
    if (idx_reg < IDX_W'(BOARD_BYTES)) begin
      if (col_reg < COL_W'(COLS)) begin
        byte_data = cell_char(cells[cell_idx]);
      end else if (col_reg == COL_W'(COLS)) begin
        byte_data = ASCII_CR;
      end else begin
        byte_data = ASCII_LF;
      end
    end else begin
      case (trail_off[1:0])
        2'd0:    byte_data = ASCII_W;
        2'd1:    byte_data = ASCII_ZERO + {6'd0, winner_snap_reg};
        2'd2:    byte_data = ASCII_CR;
        default: byte_data = ASCII_LF;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Sequencer next state, byte start, busy and done.
  always_comb begin
    state_next = state_reg;
    byte_start = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        if (send) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        byte_start = 1'b1;
        state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (byte_ready) state_next = ST_NEXT;
      end
      ST_NEXT: begin
        state_next = last_byte ? ST_FIN : ST_LOAD;
      end
      ST_FIN: begin
        done       = 1'b1;
        busy       = restart;
        state_next = restart ? ST_LOAD : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Snapshot and frame position counters (byte index, column, row).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grid_snap_reg   <= '0;
      winner_snap_reg <= '0;
      term_snap_reg   <= 1'b0;
      idx_reg         <= '0;
      col_reg         <= '0;
      row_reg         <= '0;
    end else if (take_snapshot) begin
      grid_snap_reg   <= grid;
      winner_snap_reg <= winner;
      term_snap_reg   <= term;
      idx_reg         <= '0;
      col_reg         <= '0;
      row_reg         <= '0;
    end else if ((state_reg == ST_NEXT) && !last_byte) begin
      idx_reg <= idx_reg + IDX_W'(1);
      // Column/row only walk the board area; the trailer uses the index alone.
      if (idx_reg < IDX_W'(BOARD_BYTES - 1)) begin
        if (col_reg == COL_W'(COLS + 1)) begin
          col_reg <= '0;
          row_reg <= row_reg + ROW_W'(1);
        end else begin
          col_reg <= col_reg + COL_W'(1);
        end
      end
    end
  end

  // Requests arriving mid-frame collapse into one queued frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg <= 1'b0;
    end else if (state_reg == ST_FIN) begin
      pending_reg <= 1'b0;
    end else if (send && (state_reg != ST_IDLE)) begin
      pending_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_grid_uart_tx.sv
// Bench for grid_uart_tx: a UART line monitor decodes bytes and checks bit
// widths; a board-to-text reference model gives the expected byte stream.
module tb_grid_uart_tx;

  localparam int CPB   = 4;
  localparam int LIMIT = 8000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        send = 1'b0;
  logic [97:0] grid = '0;
  logic [1:0]  winner = '0;
  logic        term = 1'b0;
  logic        tx, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int send_cyc = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [9:0] line_q[$];
  int         start_q[$];
  int         end_q[$];

  int         width_err = 0;
  int         frame_err = 0;
  logic       mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [9:0] mon_bits = '0;

  grid_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .rst    (rst),
    .send   (send),
    .grid   (grid),
    .winner (winner),
    .term   (term),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Line monitor: sample every negedge, one bit per CPB samples.
  always @(negedge clk) begin
    if (rst) begin
      mon_active <= 1'b0;
    end else if (!mon_active) begin
      if (tx == 1'b0) begin
        mon_active <= 1'b1;
        mon_cnt    <= 1;
        mon_bits   <= '0;
        start_q.push_back(cyc);
      end
    end else begin
      if (mon_cnt % CPB == 0) mon_bits[mon_cnt / CPB] <= tx;
      else if (tx !== mon_bits[mon_cnt / CPB]) width_err <= width_err + 1;
      if (mon_cnt == 10 * CPB - 1) begin
        if (mon_bits[9] !== 1'b1) frame_err <= frame_err + 1;
        rx_q.push_back(mon_bits[8:1]);
        line_q.push_back(mon_bits);
        end_q.push_back(cyc);
        mon_active <= 1'b0;
        mon_cnt    <= 0;
      end else begin
        mon_cnt <= mon_cnt + 1;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_char(input logic [1:0] c);
    case (c)
      2'b00:   return 8'h2E;
      2'b01:   return 8'h58;
      2'b10:   return 8'h4F;
      default: return 8'h3F;
    endcase
  endfunction

  // Reference: the text a terminal should show for one board dump.
  function automatic void model_frame(input logic [97:0] g, input logic t, input logic [1:0] w);
    for (int r = 6; r >= 0; r--) begin
      for (int c = 0; c < 7; c++) exp_q.push_back(model_char(g[2*(r*7+c) +: 2]));
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
    if (t) begin
      exp_q.push_back(8'h57);
      exp_q.push_back(8'h30 + {6'd0, w});
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endfunction

  function automatic logic [97:0] rand_grid();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[97:0];
  endfunction

  task automatic clear_mon();
    rx_q.delete();
    line_q.delete();
    start_q.delete();
    end_q.delete();
  endtask

  task automatic send_pulse();
    @(negedge clk);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    send_cyc = cyc;
  endtask

  // Wait for n done pulses; optionally inject new inputs and extra sends mid-frame.
  task automatic wait_frames(input string tag, input int n, input bit inject,
                             input logic [97:0] g2, input logic t2, input logic [1:0] w2);
    int dn = 0;
    int low = 0;
    for (int i = 0; i < LIMIT * n && dn < n; i++) begin
      @(negedge clk);
      if (inject) begin
        send = (i == 300 || i == 700 || i == 1100);
        if (i == 300) begin
          grid = g2;
          term = t2;
          winner = w2;
        end
      end
      if (done) dn++;
      if (done && dn == n) check_val({tag, "_busy_fall"}, busy, 0);
      else if (!busy) low++;
    end
    send = 1'b0;
    check_val({tag, "_done_cnt"}, dn, n);
    check_val({tag, "_busy_held"}, low, 0);
    repeat (20) begin
      @(negedge clk);
      if (done) dn++;
    end
    check_val({tag, "_no_extra_done"}, dn, n);
    check_val({tag, "_busy_idle"}, busy, 0);
  endtask

  task automatic compare_rx(input string tag, input int w0, input int f0);
    int gmax = 0;
    int lat;
    check_val({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check_val($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
    check_val({tag, "_bit_width"}, width_err - w0, 0);
    check_val({tag, "_stop_bit"}, frame_err - f0, 0);
    for (int i = 1; i < start_q.size() && i <= end_q.size(); i++)
      if (start_q[i] - end_q[i-1] - 1 > gmax) gmax = start_q[i] - end_q[i-1] - 1;
    check_val({tag, "_gap_le2"}, gmax <= 2, 1);
    lat = (start_q.size() > 0) ? start_q[0] - send_cyc : 999;
    check_val({tag, "_latency_le2"}, lat <= 2, 1);
  endtask

  task automatic run_frame(input string tag, input logic [97:0] g, input logic t, input logic [1:0] w);
    int w0, f0;
    grid = g;
    term = t;
    winner = w;
    exp_q.delete();
    model_frame(g, t, w);
    clear_mon();
    w0 = width_err;
    f0 = frame_err;
    send_pulse();
    check_val({tag, "_busy_rise"}, busy, 1);
    wait_frames(tag, 1, 1'b0, '0, 1'b0, 2'b00);
    compare_rx(tag, w0, f0);
    $display("frame %s: %0d bytes received, %0d expected", tag, rx_q.size(), exp_q.size());
  endtask

  initial begin
    logic [97:0] g, g1, g2;
    logic        t2;
    logic [1:0]  w2;
    int          w0, f0;
    bit          hit;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset_tx", tx, 1);
    check_val("reset_busy", busy, 0);
    check_val("reset_done", done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_frame("zero", '0, 1'b0, 2'b00);

    g = '0;
    g[1:0]   = 2'b01;
    g[97:96] = 2'b10;
    run_frame("corner", g, 1'b0, 2'b00);
    if (line_q.size() > 54) check_val("x_line_bits", line_q[54], 10'b10_1011_0000);

    run_frame("term", rand_grid(), 1'b1, 2'd2);

    for (int k = 0; k < 2; k++)
      run_frame($sformatf("rand%0d", k), rand_grid(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));

    // Queued sends plus mid-frame input changes: exactly two back-to-back frames.
    g1 = rand_grid();
    g2 = rand_grid();
    t2 = 1'b1;
    w2 = 2'($urandom_range(0, 3));
    grid = g1;
    term = 1'b0;
    winner = 2'b00;
    exp_q.delete();
    model_frame(g1, 1'b0, 2'b00);
    model_frame(g2, t2, w2);
    clear_mon();
    w0 = width_err;
    f0 = frame_err;
    send_pulse();
    check_val("queued_busy_rise", busy, 1);
    wait_frames("queued", 2, 1'b1, g2, t2, w2);
    compare_rx("queued", w0, f0);
    $display("frame queued: %0d bytes received, %0d expected", rx_q.size(), exp_q.size());

    // Reset in the middle of data bit 4 of byte 10 aborts the frame at once.
    grid = rand_grid();
    term = 1'b0;
    clear_mon();
    send_pulse();
    hit = 1'b0;
    for (int i = 0; i < LIMIT && !hit; i++) begin
      @(negedge clk);
      if (rx_q.size() == 10 && mon_active && mon_cnt == 5 * CPB + 2) hit = 1'b1;
    end
    check_val("abort_point_reached", hit, 1);
    #1 rst = 1'b1;
    #1;
    check_val("abort_tx", tx, 1);
    check_val("abort_busy", busy, 0);
    check_val("abort_done", done, 0);
    $display("reset asserted mid-byte after %0d bytes", rx_q.size());
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_val("post_abort_tx", tx, 1);
    run_frame("after_reset", rand_grid(), 1'b0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
